// File: rtl/led_matrix_driver.sv
// Row-scanned LED matrix driver with double-buffered frame memory,
// PWM brightness, an anti-ghosting gap between rows and a blank/idle mode.
module led_matrix_driver #(
    parameter int unsigned ROWS     = 20,
    parameter int unsigned COLS     = 10,
    parameter int unsigned DWELL    = 1000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    blank,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_out,
    output logic                    frame_start,
    output logic                    swap_done,
    output logic                    swap_pending
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned DW_W  = $clog2(DWELL);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [ROWS-1:0]  ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic [DW_W-1:0]     r_dwell;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_sel;
    logic [COLS-1:0]     r_buf [2][ROWS];

    state_t              w_state_nxt;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [DW_W-1:0]     w_dwell_nxt;
    logic [PWM_BITS-1:0] w_pwm_nxt;
    logic                w_sel_nxt;
    logic                w_wr_ok;
    logic                w_pend_nxt;
    logic                w_done_nxt;
    logic                w_frame_nxt;
    logic [COLS-1:0]     w_row_data;
    logic [ROWS-1:0]     w_row_sel_nxt;
    logic [COLS-1:0]     w_col_nxt;

    assign w_wr_ok   = wr_en && (32'(wr_row) < ROWS);
    assign w_pwm_nxt = r_pwm + PWM_BITS'(1);
    // The swap takes effect at the end of the cycle that shows swap_done.
    assign w_sel_nxt = r_sel ^ swap_done;

    // Scan sequencing: every output is registered from the next-cycle view.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_dwell_nxt = r_dwell;
        if (blank) begin
            w_state_nxt = IDLE;
            w_row_nxt   = '0;
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SCAN;
                    w_row_nxt   = '0;
                    w_dwell_nxt = '0;
                end
                SCAN: begin
                    if (r_dwell == DW_LAST) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_dwell_nxt = r_dwell + DW_W'(1);
                    end
                end
                GAP: begin
                    w_state_nxt = SCAN;
                    w_dwell_nxt = '0;
                    w_row_nxt   = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = '0;
                    w_dwell_nxt = '0;
                end
            endcase
        end
    end

    // Swap handshake: repeat requests while pending collapse into one swap.
    always_comb begin
        w_pend_nxt  = swap_done ? 1'b0 : (swap_pending | swap_req);
        w_done_nxt  = w_pend_nxt &&
                      ((w_state_nxt == IDLE) ||
                       ((w_state_nxt == GAP) && (w_row_nxt == ROW_LAST)));
        w_frame_nxt = (w_state_nxt == SCAN) && (r_state != SCAN) && (w_row_nxt == '0);
    end

    // A write landing on the swap edge goes straight into the new front buffer.
    always_comb begin
        w_row_data = r_buf[w_sel_nxt][w_row_nxt];
        if (swap_done && w_wr_ok && (wr_row == w_row_nxt)) begin
            w_row_data = wr_data;
        end
        w_row_sel_nxt = '0;
        w_col_nxt     = '0;
        if (w_state_nxt == SCAN) begin
            w_row_sel_nxt = ROW_ONE << w_row_nxt;
            if (w_pwm_nxt < brightness) begin
                w_col_nxt = w_row_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_dwell      <= '0;
            r_pwm        <= '0;
            r_sel        <= 1'b0;
            r_buf        <= '{default: '0};
            row_sel      <= '0;
            col_out      <= '0;
            frame_start  <= 1'b0;
            swap_done    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_dwell      <= w_dwell_nxt;
            r_pwm        <= w_pwm_nxt;
            r_sel        <= w_sel_nxt;
            row_sel      <= w_row_sel_nxt;
            col_out      <= w_col_nxt;
            frame_start  <= w_frame_nxt;
            swap_done    <= w_done_nxt;
            swap_pending <= w_pend_nxt;
            if (w_wr_ok) begin
                r_buf[~r_sel][wr_row] <= wr_data;
            end
        end
    end

endmodule
